// File: rtl/dmem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl_if
//   Bundles the two requester ports and the data-memory port of the
//   load/store sequencer.
//
//   Requester side (per port n = 0/1):
//     REQn       access request, held with stable fields until DONEn
//     WEn        1 = store, 0 = load
//     FUNCT3_n   RV32 funct3 code
//     ADDRn      byte address
//     WDATAn     store data, little-endian, right-aligned
//     DONEn      one-cycle completion pulse to the granted port
//     RDATA      formatted load result, valid with DONE0/DONE1
//     ERR        qualifies DONEn: access rejected, memory untouched
//   Memory side:
//     MEM_READ / MEM_WRITE   read / write enables
//     MEM_ADDR               byte address
//     MEM_WDATA              write data, bits [7:0] land at MEM_ADDR
//     MEM_RDATA              combinational read, byte at MEM_ADDR in [31:24]
//
//   Modports:
//     slave  - the controller
//     master - requesters plus memory (the environment around the controller)
// ----------------------------------------------------------------------------
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              REQ0;
    logic              REQ1;
    logic              WE0;
    logic              WE1;
    logic [2:0]        FUNCT3_0;
    logic [2:0]        FUNCT3_1;
    logic [ADDR_W-1:0] ADDR0;
    logic [ADDR_W-1:0] ADDR1;
    logic [31:0]       WDATA0;
    logic [31:0]       WDATA1;
    logic              DONE0;
    logic              DONE1;
    logic [31:0]       RDATA;
    logic              ERR;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, FUNCT3_0, FUNCT3_1,
        input  ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
        output DONE0, DONE1, RDATA, ERR,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, FUNCT3_0, FUNCT3_1,
        output ADDR0, ADDR1, WDATA0, WDATA1, MEM_RDATA,
        input  DONE0, DONE1, RDATA, ERR,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
//   Load/store sequencer and two-port arbiter in front of a byte-addressed
//   data memory that can only write whole 4-byte groups.
//     - Port 0: pipeline MEM stage, port 1: auxiliary (loader / debug).
//     - Round-robin on simultaneous requests, port 0 wins the first tie.
//     - Rejects illegal funct3, misaligned and out-of-range accesses.
//     - Formats LB/LH/LW/LBU/LHU results; builds SB/SH by read-modify-write.
//
//   Ports:
//     CLK      system clock, rising edge
//     RESET_N  asynchronous active-low reset
//     bus      dmem_access_ctrl_if.slave (requester ports + memory port)
//
//   Latency from grant edge to DONE cycle:
//     load 2 (RD,RESP), SW 2 (WR,RESP), SB/SH 3 (RD,WR,RESP), reject 1 (RESP)
// ----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    dmem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    // Highest start address whose 4-byte group still fits in memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic              r_rr_last;
    logic              r_port;
    logic              r_we;
    logic              r_err;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    state_t            w_next_state;
    logic              w_any_req;
    logic              w_gnt_port;
    logic              w_sel_we;
    logic [2:0]        w_sel_f3;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_f3_ok;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_reject;
    logic [31:0]       w_mem_word;
    logic [31:0]       w_load_data;

    logic              w_done0;
    logic              w_done1;
    logic [31:0]       w_rdata;
    logic              w_err;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;

    // ------------------------------------------------------------------------
    // Arbitration: on a tie serve the port that was not served last.
    // ------------------------------------------------------------------------
    assign w_any_req  = bus.REQ0 | bus.REQ1;
    assign w_gnt_port = (bus.REQ0 & bus.REQ1) ? ~r_rr_last : bus.REQ1;

    assign w_sel_we    = w_gnt_port ? bus.WE1      : bus.WE0;
    assign w_sel_f3    = w_gnt_port ? bus.FUNCT3_1 : bus.FUNCT3_0;
    assign w_sel_addr  = w_gnt_port ? bus.ADDR1    : bus.ADDR0;
    assign w_sel_wdata = w_gnt_port ? bus.WDATA1   : bus.WDATA0;

    // ------------------------------------------------------------------------
    // Request checks, evaluated on the granted port's fields.
    // ------------------------------------------------------------------------
    always_comb begin
        w_f3_ok = 1'b0;
        case (w_sel_f3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = ~w_sel_we;
            default:                w_f3_ok = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the access size for every legal code.
    assign w_misaligned   = ((w_sel_f3[1:0] == 2'b01) && w_sel_addr[0]) ||
                            ((w_sel_f3[1:0] == 2'b10) && (w_sel_addr[1:0] != 2'b00));
    assign w_out_of_range = w_sel_addr > LAST_ADDR;
    assign w_reject       = ~w_f3_ok | w_misaligned | w_out_of_range;

    // Memory returns the addressed byte in the top lane; turn it little-endian.
    assign w_mem_word = {bus.MEM_RDATA[7:0],   bus.MEM_RDATA[15:8],
                         bus.MEM_RDATA[23:16], bus.MEM_RDATA[31:24]};

    // ------------------------------------------------------------------------
    // Load result formatting from the captured word.
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_data = '0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{r_word[7]}}, r_word[7:0]};
            3'b001:  w_load_data = {{16{r_word[15]}}, r_word[15:0]};
            3'b010:  w_load_data = r_word;
            3'b100:  w_load_data = {24'd0, r_word[7:0]};
            3'b101:  w_load_data = {16'd0, r_word[15:0]};
            default: w_load_data = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and latched request fields
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_rr_last <= 1'b1;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_funct3  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_word    <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_any_req) begin
                r_port    <= w_gnt_port;
                r_rr_last <= w_gnt_port;
                r_we      <= w_sel_we;
                r_funct3  <= w_sel_f3;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
                r_err     <= w_reject;
            end
            if (r_state == RD) begin
                r_word <= w_mem_word;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and output decode. MEM_* depend only on registered state and
    // latched fields, never on the live request inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_done0      = 1'b0;
        w_done1      = 1'b0;
        w_rdata      = '0;
        w_err        = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    if (w_reject) begin
                        w_next_state = RESP;
                    end else if (w_sel_we && (w_sel_f3[1:0] == 2'b10)) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end

            RD: begin
                w_mem_read   = 1'b1;
                w_mem_addr   = r_addr;
                w_next_state = r_we ? WR : RESP;
            end

            WR: begin
                w_mem_write = 1'b1;
                w_mem_addr  = r_addr;
                // Sub-word stores merge new bytes into the word read in RD.
                case (r_funct3[1:0])
                    2'b00:   w_mem_wdata = {r_word[31:8], r_wdata[7:0]};
                    2'b01:   w_mem_wdata = {r_word[31:16], r_wdata[15:0]};
                    default: w_mem_wdata = r_wdata;
                endcase
                w_next_state = RESP;
            end

            RESP: begin
                w_done0      = ~r_port;
                w_done1      = r_port;
                w_err        = r_err;
                w_rdata      = (r_err | r_we) ? '0 : w_load_data;
                w_next_state = IDLE;
            end

            default: w_next_state = IDLE;
        endcase
    end

    assign bus.DONE0     = w_done0;
    assign bus.DONE1     = w_done1;
    assign bus.RDATA     = w_rdata;
    assign bus.ERR       = w_err;
    assign bus.MEM_READ  = w_mem_read;
    assign bus.MEM_WRITE = w_mem_write;
    assign bus.MEM_ADDR  = w_mem_addr;
    assign bus.MEM_WDATA = w_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Drives dmem_access_ctrl through the interface, emulates the data memory,
//   and checks every completion against a byte-array reference model that
//   applies the access rules directly (size, alignment, range, extension).
// ----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned ADDR_W    = 32;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLK = ~CLK;

    dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_access_ctrl #(
        .MEM_BYTES(MEM_BYTES),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    logic [7:0] mem     [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    int errors = 0;
    int checks = 0;
    int wr_pulses = 0;

    // Memory emulation: top byte lane holds the addressed byte on reads,
    // bottom byte lane lands at the address on writes.
    always_comb begin
        bus.MEM_RDATA = '0;
        if (bus.MEM_ADDR <= ADDR_W'(MEM_BYTES - 4)) begin
            for (int i = 0; i < 4; i++) begin
                bus.MEM_RDATA[31-8*i -: 8] = mem[int'(bus.MEM_ADDR) + i];
            end
        end
    end

    always @(posedge CLK) begin
        if (bus.MEM_WRITE) begin
            wr_pulses = wr_pulses + 1;
            if (bus.MEM_ADDR <= ADDR_W'(MEM_BYTES - 4)) begin
                for (int i = 0; i < 4; i++) begin
                    mem[int'(bus.MEM_ADDR) + i] = bus.MEM_WDATA[8*i +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        mem[a]     = b;
        ref_mem[a] = b;
    endtask

    // Reference model: one whole access at transaction level.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err,
                              output logic [31:0] rdata, output int n_writes, output int lat);
        int size;
        bit legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        err   = !legal || ((addr % size) != 0) || (addr > 32'(MEM_BYTES - 4));
        rdata = '0;
        n_writes = 0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            n_writes = 1;
            lat = (size == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            rdata = v;
            lat = 2;
        end
    endtask

    task automatic drive_port(input int p, input logic req, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.REQ0 = req; bus.WE0 = we; bus.FUNCT3_0 = f3; bus.ADDR0 = addr; bus.WDATA0 = wdata;
        end else begin
            bus.REQ1 = req; bus.WE1 = we; bus.FUNCT3_1 = f3; bus.ADDR1 = addr; bus.WDATA1 = wdata;
        end
    endtask

    // Random request, mostly legal, sometimes with a bad code or address.
    task automatic gen(output logic we, output logic [2:0] f3, output logic [31:0] addr,
                       output logic [31:0] wdata);
        int k;
        logic [31:0] mask;
        we = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin
            f3 = 3'($urandom_range(0, 7));
        end else if (we) begin
            f3 = 3'($urandom_range(0, 2));
        end else begin
            k  = $urandom_range(0, 4);
            f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        end
        if ($urandom_range(0, 7) == 0) begin
            addr = $urandom_range(0, MEM_BYTES - 1);
        end else begin
            mask = (f3[1:0] == 2'b01) ? 32'hFFFF_FFFE :
                   (f3[1:0] == 2'b10) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF;
            addr = 32'($urandom_range(0, MEM_BYTES - 4)) & mask;
        end
        wdata = $urandom;
    endtask

    // Single-port access: checks latency, result, ERR, port steering and
    // the number of memory write cycles.
    task automatic do_txn(input int p, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] got);
        logic e_err, seen, other, g_err;
        logic [31:0] e_rd;
        int e_wr, e_lat, cyc;
        ref_access(we, f3, addr, wdata, e_err, e_rd, e_wr, e_lat);
        wr_pulses = 0;
        drive_port(p, 1'b1, we, f3, addr, wdata);
        cyc = 0; seen = 0; other = 0; got = '0; g_err = 0;
        while (!seen && cyc < 8) begin
            @(posedge CLK); @(negedge CLK);
            cyc++;
            if (p == 0 ? bus.DONE1 : bus.DONE0) other = 1;
            if (p == 0 ? bus.DONE0 : bus.DONE1) begin
                seen  = 1;
                got   = bus.RDATA;
                g_err = bus.ERR;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_lat"},   32'(cyc),   32'(e_lat));
            check({tag, "_rdata"}, got,        e_rd);
            check({tag, "_err"},   32'(g_err), 32'(e_err));
        end
        check({tag, "_wrong_port"}, 32'(other), 32'd0);
        drive_port(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge CLK); @(negedge CLK);
        check({tag, "_writes"}, 32'(wr_pulses), 32'(e_wr));
    endtask

    // Both ports request continuously; each re-raises one cycle after its DONE.
    task automatic dual_run(input int n);
        logic cw [2];
        logic [2:0] cf [2];
        logic [31:0] ca [2];
        logic [31:0] cd [2];
        logic pend [2];
        logic d [2];
        logic e_err;
        logic [31:0] e_rd;
        int e_wr, e_lat, expect_port, done_cnt, guard;
        RESET_N = 1'b0;
        for (int p = 0; p < 2; p++) begin
            gen(cw[p], cf[p], ca[p], cd[p]);
            drive_port(p, 1'b1, cw[p], cf[p], ca[p], cd[p]);
            pend[p] = 0;
        end
        @(negedge CLK);
        check("rst_held_mem_read", 32'(bus.MEM_READ | bus.MEM_WRITE), 32'd0);
        check("rst_held_done", 32'(bus.DONE0 | bus.DONE1), 32'd0);
        RESET_N = 1'b1;
        expect_port = 0; done_cnt = 0; guard = 0;
        while (done_cnt < n && guard < n * 6) begin
            @(posedge CLK); @(negedge CLK);
            guard++;
            d[0] = bus.DONE0;
            d[1] = bus.DONE1;
            if (d[0] && d[1]) check("dual_one_done", 32'd1, 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) begin
                    gen(cw[p], cf[p], ca[p], cd[p]);
                    drive_port(p, 1'b1, cw[p], cf[p], ca[p], cd[p]);
                    pend[p] = 0;
                end else if (d[p]) begin
                    ref_access(cw[p], cf[p], ca[p], cd[p], e_err, e_rd, e_wr, e_lat);
                    check("dual_grant_order", 32'(p), 32'(expect_port));
                    check("dual_rdata", bus.RDATA, e_rd);
                    check("dual_err", 32'(bus.ERR), 32'(e_err));
                    expect_port = 1 - p;
                    drive_port(p, 1'b0, cw[p], cf[p], ca[p], cd[p]);
                    pend[p] = 1;
                    done_cnt++;
                end
            end
        end
        check("dual_count", 32'(done_cnt), 32'(n));
        drive_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) begin @(posedge CLK); @(negedge CLK); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, a, d;
        logic we;
        logic [2:0] f3;
        int seen, diff, p;

        for (int i = 0; i < MEM_BYTES; i++) poke(i, 8'($urandom));
        drive_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_port(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_done", 32'({bus.DONE0, bus.DONE1, bus.ERR}), 32'd0);
        check("rst_rdata", bus.RDATA, 32'd0);
        check("rst_mem_en", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
        check("rst_mem_addr", bus.MEM_ADDR, 32'd0);
        check("rst_mem_wdata", bus.MEM_WDATA, 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Word store and load-back
        do_txn(0, 1'b1, 3'b010, 32'h10, 32'h8899_AABB, "sw10", got);
        do_txn(0, 1'b0, 3'b010, 32'h10, 32'd0, "lw10", got);
        check("lw10_const", got, 32'h8899_AABB);

        // Sub-word loads with sign/zero extension
        poke(32'h20, 8'h80);
        poke(32'h21, 8'hFF);
        do_txn(0, 1'b0, 3'b000, 32'h20, 32'd0, "lb20", got);
        check("lb20_const", got, 32'hFFFF_FF80);
        do_txn(0, 1'b0, 3'b100, 32'h20, 32'd0, "lbu20", got);
        check("lbu20_const", got, 32'h0000_0080);
        do_txn(0, 1'b0, 3'b001, 32'h20, 32'd0, "lh20", got);
        check("lh20_const", got, 32'hFFFF_FF80);
        do_txn(0, 1'b0, 3'b101, 32'h20, 32'd0, "lhu20", got);
        check("lhu20_const", got, 32'h0000_FF80);

        // Read-modify-write sub-word stores
        poke(32'h30, 8'h44); poke(32'h31, 8'h33); poke(32'h32, 8'h22); poke(32'h33, 8'h11);
        do_txn(0, 1'b1, 3'b000, 32'h30, 32'h0000_00AB, "sb30", got);
        do_txn(0, 1'b0, 3'b010, 32'h30, 32'd0, "lw30a", got);
        check("lw30a_const", got, 32'h1122_33AB);
        do_txn(0, 1'b1, 3'b001, 32'h32, 32'h0000_BEEF, "sh32", got);
        do_txn(0, 1'b0, 3'b010, 32'h30, 32'd0, "lw30b", got);
        check("lw30b_const", got, 32'hBEEF_33AB);

        // Rejected accesses and range boundary
        do_txn(0, 1'b0, 3'b010, 32'h13, 32'd0, "err_lw13", got);
        do_txn(0, 1'b1, 3'b001, 32'h21, 32'h1234, "err_sh21", got);
        do_txn(0, 1'b0, 3'b010, 32'h3FE, 32'd0, "err_lw3fe", got);
        do_txn(0, 1'b0, 3'b011, 32'h10, 32'd0, "err_f3_ld", got);
        do_txn(0, 1'b1, 3'b011, 32'h10, 32'h5555_5555, "err_f3_st", got);
        do_txn(0, 1'b1, 3'b100, 32'h10, 32'h6666_6666, "err_st_lbu", got);
        do_txn(1, 1'b0, 3'b000, 32'h3FD, 32'd0, "err_lb3fd", got);
        do_txn(1, 1'b1, 3'b010, 32'hFFFF_FFFC, 32'h7777_7777, "err_far", got);
        do_txn(1, 1'b1, 3'b010, 32'h3FC, 32'hCAFE_F00D, "sw3fc", got);
        do_txn(0, 1'b0, 3'b010, 32'h3FC, 32'd0, "lw3fc", got);
        do_txn(1, 1'b1, 3'b010, 32'h50, 32'h0BAD_CAFE, "sw50_p1", got);
        do_txn(0, 1'b0, 3'b010, 32'h50, 32'd0, "lw50_p0", got);

        // Reset during WR aborts the store
        poke(32'h40, 8'h01); poke(32'h41, 8'h02); poke(32'h42, 8'h03); poke(32'h43, 8'h04);
        wr_pulses = 0;
        drive_port(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF);
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            @(posedge CLK); @(negedge CLK);
            if (bus.MEM_WRITE) seen = 1;
        end
        check("rstwr_reached_wr", 32'(seen), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("rstwr_mem_write", 32'(bus.MEM_WRITE), 32'd0);
        drive_port(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge CLK); @(negedge CLK);
        check("rstwr_no_done", 32'(bus.DONE0 | bus.DONE1), 32'd0);
        check("rstwr_writes", 32'(wr_pulses), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        do_txn(0, 1'b0, 3'b010, 32'h40, 32'd0, "lw40", got);
        check("lw40_const", got, 32'h0403_0201);

        // Random single-port traffic
        for (int t = 0; t < 60; t++) begin
            gen(we, f3, a, d);
            p = $urandom_range(0, 1);
            do_txn(p, we, f3, a, d, "rnd", got);
        end

        // Continuous contention from reset
        dual_run(24);

        diff = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Load/store sequencer and two-port arbiter in front of the byte-addressed data memory.
- Port 0 is the pipeline MEM stage. Port 1 is the auxiliary port (program loader / debug).
- Arbitrates between the ports, checks alignment and range, and formats RV32 sub-word loads (sign/zero extension).
- Builds SB/SH from a read-modify-write sequence, because the memory only writes 4 bytes at a time.

Parameters:
MEM_BYTES, 1024, memory size in bytes; a legal access needs ADDR+3 <= MEM_BYTES-1
ADDR_W, 32, requester and memory address width

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
REQ0 / REQ1  in  1  access request, one per port; held high with its fields stable until DONEn
WE0 / WE1  in  1  1 = store, 0 = load
FUNCT3_0 / FUNCT3_1  in  3  RV32 funct3 code
ADDR0 / ADDR1  in  ADDR_W  byte address
WDATA0 / WDATA1  in  32  store data, little-endian, right-aligned
DONE0 / DONE1  out  1  one-cycle completion pulse to the granted port
RDATA  out  32  formatted load result, valid while DONE0 or DONE1 is high
ERR  out  1  qualifies DONEn: access rejected, memory untouched
MEM_READ  out  1  memory read enable
MEM_WRITE  out  1  memory write enable
MEM_ADDR  out  ADDR_W  memory byte address
MEM_WDATA  out  32  memory write data; bits [7:0] are written to MEM_ADDR
MEM_RDATA  in  32  combinational memory read; byte at MEM_ADDR is in bits [31:24]

Behaviour:
- Reset (async, RESET_N=0):
  - State = IDLE; rr_last = 1, so port 0 wins the first tie.
  - All outputs 0, latched request fields 0.
  - Reset during WR drops MEM_WRITE immediately: no write occurs, and no DONE is issued for the aborted access.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - Only REQ0 high → grant 0. Only REQ1 high → grant 1. Both high → grant the port != rr_last; rr_last <= granted port.
  - Latch the granted port's WE, FUNCT3, ADDR, WDATA.
  - Request is checked at grant time; failing any check → go to RESP with ERR=1.
- Request checks:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Halfword access requires ADDR[0]=0; word access requires ADDR[1:0]=00.
  - ADDR > MEM_BYTES-4 is out of range.
- Next state after a good grant: load, SB or SH → RD; SW → WR.
- RD:
  - MEM_READ=1, MEM_ADDR=latched ADDR.
  - Capture word byte-swapped to little-endian: w = {MEM_RDATA[7:0], MEM_RDATA[15:8], MEM_RDATA[23:16], MEM_RDATA[31:24]}.
  - Load → RESP; SB/SH → WR.
- WR:
  - MEM_WRITE=1, MEM_ADDR=latched ADDR. The memory commits at the rising edge that ends WR.
  - MEM_WDATA by store type:
    - SW: WDATA.
    - SH: {w[31:16], WDATA[15:0]}.
    - SB: {w[31:8], WDATA[7:0]}.
  - Next state RESP.
- RESP:
  - DONEn=1 for the granted port only, for exactly one cycle; ERR as determined at grant.
  - Load result on RDATA:
    - LB: sign-extended w[7:0]; LBU: zero-extended w[7:0].
    - LH: sign-extended w[15:0]; LHU: zero-extended w[15:0].
    - LW: w.
  - Stores and errors: RDATA=0.
  - Next state IDLE.
- Output decode:
  - MEM_* are decoded from the registered state and latched fields; no combinational path from REQ to MEM_*.
  - MEM_READ/MEM_WRITE are 0 in IDLE and RESP; MEM_ADDR/MEM_WDATA are 0 outside RD/WR.
- Latency, counted as cycles from the grant edge to the DONE cycle:
  - Load: 2 (RD, RESP).
  - SW: 2 (WR, RESP).
  - SB/SH: 3 (RD, WR, RESP).
  - Error: 1 (RESP).
- Requester rules:
  - Must drop REQ in the cycle after DONE. A REQ still high in IDLE is taken as a new request.
  - A non-granted port's REQ is ignored until the FSM returns to IDLE.
  - The pipeline stall signal is REQ0 & ~DONE0.
- Fairness: with both ports requesting continuously, grants alternate 0,1,0,1…

Test Plan:
- Reset then SW port0 ADDR=0x10 WDATA=0x8899AABB; then LW 0x10 → DONE0 after 2 cycles each, RDATA=0x8899AABB, ERR=0.
- Memory byte 0x20=0x80: LB → RDATA=0xFFFFFF80; LBU → 0x00000080. Bytes 0x20..21=0x80,0xFF (byte 0x21=0xFF, byte 0x20=0x80): LH → 0xFFFFFF80; LHU → 0x0000FF80.
- Word 0x30=0x11223344, SB 0x30 WDATA=0xAB → RD/WR sequence, DONE 3 cycles after grant, LW 0x30=0x112233AB; SH 0x32 WDATA=0xBEEF → word 0x30 = 0xBEEF33AB.
- LW 0x13, SH 0x21, LW 0x3FE (MEM_BYTES=1024), funct3=011 → ERR=1 with DONE 1 cycle after grant; MEM_WRITE never asserted; memory unchanged.
- REQ0 and REQ1 held continuously from reset → grant order 0,1,0,1; each port's DONE only to itself; the held fields of the waiting port are preserved.
- RESET_N pulsed low during WR of SW 0x40=0xDEADBEEF → MEM_WRITE drops asynchronously, no DONE; LW 0x40 after reset returns the prior contents.
